// File: rtl/router_pkg.sv
// Shared constants, state encoding and credit helpers for the router dispatch controller.
package router_pkg;

    localparam logic [1:0] DIR_SELF  = 2'b01;
    localparam logic [1:0] DIR_RIGHT = 2'b00;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_BAD   = 2'b11;

    localparam int CRED_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        GAP   = 2'b10
    } state_t;

    // An illegal direction never needs a credit: it is accepted and discarded.
    function automatic logic has_credit(input logic [1:0]        dir,
                                        input logic [CRED_W-1:0] c_self,
                                        input logic [CRED_W-1:0] c_left,
                                        input logic [CRED_W-1:0] c_right);
        logic ok;
        case (dir)
            DIR_SELF:  ok = (c_self  != {CRED_W{1'b0}});
            DIR_LEFT:  ok = (c_left  != {CRED_W{1'b0}});
            DIR_RIGHT: ok = (c_right != {CRED_W{1'b0}});
            default:   ok = 1'b1;
        endcase
        return ok;
    endfunction

    function automatic logic [CRED_W-1:0] cred_step(input logic [CRED_W-1:0] cur,
                                                    input logic              dec,
                                                    input logic              inc,
                                                    input logic [CRED_W-1:0] max);
        logic [CRED_W-1:0] nxt;
        if (dec && !inc) begin
            nxt = cur - CRED_W'(1);
        end else if (inc && !dec && (cur != max)) begin
            nxt = cur + CRED_W'(1);
        end else begin
            nxt = cur;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/router_dispatch_ctrl_if.sv
// Requester handshake, credit returns and master_spi drive bundle of the dispatch controller.
interface router_dispatch_ctrl_if #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_instr;
    logic [NREQ*2-1:0]     req_dir;
    logic                  ret_self;
    logic                  ret_left;
    logic                  ret_right;
    logic                  new_instr;
    logic [1:0]            enable;
    logic [WIDTH-1:0]      out_instr;
    logic                  busy;
    logic                  drop_err;
    logic                  cred_err;

    modport master (
        output req_valid, req_instr, req_dir, ret_self, ret_left, ret_right,
        input  req_ready, new_instr, enable, out_instr, busy, drop_err, cred_err
    );

    modport slave (
        input  req_valid, req_instr, req_dir, ret_self, ret_left, ret_right,
        output req_ready, new_instr, enable, out_instr, busy, drop_err, cred_err
    );
endinterface

// File: rtl/router_dispatch_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first eligible requester at or after ptr, wrapping.
module rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  eligible,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [PTR_W-1:0] grant_idx,
    output logic             grant_any
);
    logic found_s;

    // Pass 0 scans from ptr upward, pass 1 wraps to the indices below ptr.
    always_comb begin
        grant     = {NREQ{1'b0}};
        grant_idx = {PTR_W{1'b0}};
        found_s   = 1'b0;
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!found_s && eligible[i] && ((pass == 0) == (i >= int'(ptr)))) begin
                    found_s   = 1'b1;
                    grant[i]  = 1'b1;
                    grant_idx = PTR_W'(i);
                end else begin
                    found_s = found_s;
                end
            end
        end
    end

    assign grant_any = found_s;

endmodule

// File: rtl/router_dispatch_ctrl.sv
// Shares the master_spi instruction router between NREQ sources with per-direction credits.
// Optional DISPATCH_STATS_EN adds saturating per-direction ISSUE counters.
module router_dispatch_ctrl
    import router_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NREQ    = 4,
    parameter int CREDITS = 2
) (
    input  logic clk,
    input  logic reset,
    router_dispatch_ctrl_if.slave bus
`ifdef DISPATCH_STATS_EN
    ,
    output logic [15:0] stat_self,
    output logic [15:0] stat_left,
    output logic [15:0] stat_right
`endif
);
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(CREDITS);

    state_t            state_r, state_s;
    logic [PTR_W-1:0]  ptr_r;
    logic [CRED_W-1:0] cred_self_r, cred_left_r, cred_right_r;
    logic [CRED_W-1:0] cred_self_s, cred_left_s, cred_right_s;
    logic [NREQ-1:0]   eligible_s, grant_s;
    logic [PTR_W-1:0]  grant_idx_s;
    logic              grant_any_s;
    logic [1:0]        sel_dir_s;
    logic [WIDTH-1:0]  sel_instr_s;
    logic              accept_s, legal_s;
    logic              dec_self_s, dec_left_s, dec_right_s, cred_err_s;
    logic              new_instr_r, busy_r, drop_err_r, cred_err_r;
    logic [1:0]        enable_r;
    logic [WIDTH-1:0]  out_instr_r;

    // Eligible requesters: only while IDLE, and only if the target direction has a credit.
    always_comb begin
        eligible_s = {NREQ{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            eligible_s[i] = bus.req_valid[i] && (state_r == IDLE) &&
                            has_credit(bus.req_dir[i*2 +: 2], cred_self_r, cred_left_r, cred_right_r);
        end
    end

    rr_arbiter #(.NREQ(NREQ), .PTR_W(PTR_W)) u_arb (
        .eligible  (eligible_s),
        .ptr       (ptr_r),
        .grant     (grant_s),
        .grant_idx (grant_idx_s),
        .grant_any (grant_any_s)
    );

    // One-hot grant lets the winner's fields be selected with an AND-OR mux.
    always_comb begin
        sel_dir_s   = 2'b00;
        sel_instr_s = {WIDTH{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            sel_dir_s   = sel_dir_s   | ({2{grant_s[i]}} & bus.req_dir[i*2 +: 2]);
            sel_instr_s = sel_instr_s | ({WIDTH{grant_s[i]}} & bus.req_instr[i*WIDTH +: WIDTH]);
        end
    end

    assign accept_s = grant_any_s;
    assign legal_s  = grant_any_s && (sel_dir_s != DIR_BAD);

    // Next-state logic: a legal transfer starts the ISSUE/GAP sequence.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (legal_s) begin
                    state_s = ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE:   state_s = GAP;
            GAP:     state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Credit bookkeeping; a return into a full counter is flagged instead of counted.
    always_comb begin
        dec_self_s   = legal_s && (sel_dir_s == DIR_SELF);
        dec_left_s   = legal_s && (sel_dir_s == DIR_LEFT);
        dec_right_s  = legal_s && (sel_dir_s == DIR_RIGHT);
        cred_self_s  = cred_step(cred_self_r,  dec_self_s,  bus.ret_self,  CRED_MAX);
        cred_left_s  = cred_step(cred_left_r,  dec_left_s,  bus.ret_left,  CRED_MAX);
        cred_right_s = cred_step(cred_right_r, dec_right_s, bus.ret_right, CRED_MAX);
        cred_err_s   = (bus.ret_self  && !dec_self_s  && (cred_self_r  == CRED_MAX)) ||
                       (bus.ret_left  && !dec_left_s  && (cred_left_r  == CRED_MAX)) ||
                       (bus.ret_right && !dec_right_s && (cred_right_r == CRED_MAX));
    end

    // State, pointer, credits and registered master_spi/status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            ptr_r        <= {PTR_W{1'b0}};
            cred_self_r  <= CRED_MAX;
            cred_left_r  <= CRED_MAX;
            cred_right_r <= CRED_MAX;
            new_instr_r  <= 1'b0;
            busy_r       <= 1'b0;
            enable_r     <= DIR_SELF;
            out_instr_r  <= {WIDTH{1'b0}};
            drop_err_r   <= 1'b0;
            cred_err_r   <= 1'b0;
        end else begin
            state_r      <= state_s;
            cred_self_r  <= cred_self_s;
            cred_left_r  <= cred_left_s;
            cred_right_r <= cred_right_s;
            if (accept_s) begin
                ptr_r <= (grant_idx_s == PTR_W'(NREQ - 1)) ? {PTR_W{1'b0}} : grant_idx_s + PTR_W'(1);
            end
            if (legal_s) begin
                enable_r    <= sel_dir_s;
                out_instr_r <= sel_instr_s;
            end
            new_instr_r <= (state_s == ISSUE);
            busy_r      <= (state_s != IDLE);
            drop_err_r  <= accept_s && !legal_s;
            cred_err_r  <= cred_err_s;
        end
    end

    assign bus.req_ready = grant_s;
    assign bus.new_instr = new_instr_r;
    assign bus.enable    = enable_r;
    assign bus.out_instr = out_instr_r;
    assign bus.busy      = busy_r;
    assign bus.drop_err  = drop_err_r;
    assign bus.cred_err  = cred_err_r;

`ifdef DISPATCH_STATS_EN
    logic [15:0] stat_self_r, stat_left_r, stat_right_r;

    // Saturating count of ISSUE cycles per dispatched direction.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_self_r  <= 16'h0000;
            stat_left_r  <= 16'h0000;
            stat_right_r <= 16'h0000;
        end else if (state_r == ISSUE) begin
            case (enable_r)
                DIR_SELF:  if (stat_self_r  != 16'hFFFF) stat_self_r  <= stat_self_r  + 16'h0001;
                DIR_LEFT:  if (stat_left_r  != 16'hFFFF) stat_left_r  <= stat_left_r  + 16'h0001;
                DIR_RIGHT: if (stat_right_r != 16'hFFFF) stat_right_r <= stat_right_r + 16'h0001;
                default:   stat_self_r <= stat_self_r;
            endcase
        end
    end

    assign stat_self  = stat_self_r;
    assign stat_left  = stat_left_r;
    assign stat_right = stat_right_r;
`endif

endmodule

// File: tb/tb_router_dispatch_ctrl.sv
// Self-checking bench: scripted opening cycles then randomized traffic against a reference model.
module tb_router_dispatch_ctrl;
    localparam int WIDTH   = 32;
    localparam int NREQ    = 4;
    localparam int CREDITS = 2;
    localparam int NCYC    = 3000;

    logic clk;
    logic reset;

    router_dispatch_ctrl_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

`ifdef DISPATCH_STATS_EN
    logic [15:0] stat_self, stat_left, stat_right;
`endif

    router_dispatch_ctrl #(.WIDTH(WIDTH), .NREQ(NREQ), .CREDITS(CREDITS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef DISPATCH_STATS_EN
        ,
        .stat_self  (stat_self),
        .stat_left  (stat_left),
        .stat_right (stat_right)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: credits indexed 0=self 1=left 2=right; m_busy counts cycles left occupied.
    int          m_cred [3];
    int          m_stat [3];
    int          m_ptr;
    int          m_busy;
    logic [1:0]  m_en;
    logic [31:0] m_out;
    logic        m_drop;
    logic        m_cerr;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic int dir_idx(input logic [1:0] d);
        case (d)
            2'b01:   return 0;
            2'b10:   return 1;
            2'b00:   return 2;
            default: return -1;
        endcase
    endfunction

    function automatic int model_winner();
        logic [1:0] d;
        int         i;
        if (m_busy != 0) return -1;
        for (int k = 0; k < NREQ; k++) begin
            i = (m_ptr + k) % NREQ;
            d = bus.req_dir[i*2 +: 2];
            if (bus.req_valid[i] && (d == 2'b11 || m_cred[dir_idx(d)] > 0)) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int j = 0; j < 3; j++) begin
            m_cred[j] = CREDITS;
            m_stat[j] = 0;
        end
        m_ptr  = 0;
        m_busy = 0;
        m_en   = 2'b01;
        m_out  = 32'h0;
        m_drop = 1'b0;
        m_cerr = 1'b0;
    endtask

    task automatic model_edge();
        int         w;
        int         disp;
        logic [1:0] d;
        logic       rets [3];
        logic       inc, dec;
        if (reset) begin
            model_reset();
            return;
        end
        w    = model_winner();
        disp = -1;
        if (m_busy == 2 && m_stat[dir_idx(m_en)] < 65535) m_stat[dir_idx(m_en)]++;
        if (m_busy > 0) m_busy--;
        m_drop = 1'b0;
        if (w >= 0) begin
            d     = bus.req_dir[w*2 +: 2];
            m_ptr = (w + 1) % NREQ;
            if (d == 2'b11) begin
                m_drop = 1'b1;
            end else begin
                disp   = dir_idx(d);
                m_busy = 2;
                m_en   = d;
                m_out  = bus.req_instr[w*WIDTH +: WIDTH];
            end
        end
        rets[0] = bus.ret_self;
        rets[1] = bus.ret_left;
        rets[2] = bus.ret_right;
        m_cerr  = 1'b0;
        for (int j = 0; j < 3; j++) begin
            dec = (disp == j);
            inc = rets[j];
            if (inc && !dec) begin
                if (m_cred[j] == CREDITS) m_cerr = 1'b1;
                else m_cred[j]++;
            end else if (dec && !inc) begin
                m_cred[j]--;
            end
        end
    endtask

    task automatic clear_inputs();
        bus.req_valid = '0;
        bus.req_instr = '0;
        bus.req_dir   = '0;
        bus.ret_self  = 1'b0;
        bus.ret_left  = 1'b0;
        bus.ret_right = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [1:0] d, input logic [31:0] ins);
        bus.req_valid[i]               = 1'b1;
        bus.req_dir[i*2 +: 2]          = d;
        bus.req_instr[i*WIDTH +: WIDTH] = ins;
    endtask

    // Scripted opening: single dispatch, illegal dir on req2, reset during an ISSUE cycle.
    task automatic drive(input int c);
        int         sel;
        int         ret_div;
        logic [1:0] d;
        clear_inputs();
        reset = 1'b0;
        if (c < 2) begin
            reset = 1'b1;
        end else if (c == 2) begin
            set_req(0, 2'b01, 32'hDEADBEEF);
        end else if (c == 5) begin
            set_req(2, 2'b11, 32'hBAD0BAD0);
        end else if (c == 7) begin
            set_req(1, 2'b00, 32'h00001234);
        end else if (c == 8) begin
            reset = 1'b1;
        end else if (c >= 12) begin
            reset = ($urandom_range(0, 399) == 0);
            for (int i = 0; i < NREQ; i++) begin
                sel = $urandom_range(0, 15);
                d   = (sel == 0) ? 2'b11 : (sel < 6) ? 2'b01 : (sel < 11) ? 2'b10 : 2'b00;
                if ($urandom_range(0, 3) != 0) set_req(i, d, $urandom);
            end
            ret_div       = (c < NCYC / 2) ? 15 : 3;
            bus.ret_self  = ($urandom_range(0, ret_div) == 0);
            bus.ret_left  = ($urandom_range(0, ret_div) == 0);
            bus.ret_right = ($urandom_range(0, ret_div) == 0);
        end
    endtask

    initial begin
        int w;
        reset = 1'b1;
        clear_inputs();
        model_reset();
        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            model_edge();
            #1;
            drive(c);
            @(negedge clk);
            w = model_winner();
            check_eq("req_ready", 64'(bus.req_ready), (w >= 0) ? (64'd1 << w) : 64'd0);
            check_eq("new_instr", 64'(bus.new_instr), 64'(m_busy == 2));
            check_eq("busy",      64'(bus.busy),      64'(m_busy != 0));
            check_eq("enable",    64'(bus.enable),    64'(m_en));
            check_eq("out_instr", 64'(bus.out_instr), 64'(m_out));
            check_eq("drop_err",  64'(bus.drop_err),  64'(m_drop));
            check_eq("cred_err",  64'(bus.cred_err),  64'(m_cerr));
`ifdef DISPATCH_STATS_EN
            check_eq("stat_self",  64'(stat_self),  64'(m_stat[0]));
            check_eq("stat_left",  64'(stat_left),  64'(m_stat[1]));
            check_eq("stat_right", 64'(stat_right), 64'(m_stat[2]));
`endif
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
